// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Segment vectors are active-low, bit 0 = segment a through bit 6 = segment g.
package sseg_pkg;

    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_e;

    localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/sseg_scan_driver_bcd_to_sseg.sv
// Purely combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not decimal and show a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg
);

    // Map one BCD code to its segment pattern.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Each digit owns a slot of SLOT_CYC cycles; the first BLANK_CYC cycles of a slot keep all
// anodes off to avoid ghosting. Digits are captured into a shadow register on i_load so the
// display never shows a half-updated value. All outputs are registered.
// Optional build macro SSEG_LEAD_ZERO_BLANK_EN enables leading-zero blanking.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [BCD_W-1:0] i_d0,
    input  logic [BCD_W-1:0] i_d1,
    input  logic [BCD_W-1:0] i_d2,
    input  logic [BCD_W-1:0] i_d3,
    input  logic             i_load,
    input  logic [NUM_DIG-1:0] i_dp_sel,
    output logic [NUM_DIG-1:0] o_an,
    output logic [SEG_W-1:0] o_seg,
    output logic             o_dp
);

    localparam int unsigned PRESC_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SLOT_CYC - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYC);

    logic [NUM_DIG-1:0][BCD_W-1:0] r_digits;
    logic [NUM_DIG-1:0]            r_dp_sel;
    logic [PRESC_W-1:0]            r_presc;
    scan_state_e                   r_state;
    scan_state_e                   w_state_nxt;
    logic [1:0]                    w_idx;
    logic                          w_slot_end;
    logic [BCD_W-1:0]              w_digit;
    logic [SEG_W-1:0]              w_seg_dec;
    logic [SEG_W-1:0]              w_seg_nxt;
    logic [NUM_DIG-1:0]            w_an_nxt;
    logic [NUM_DIG-1:0]            r_an;
    logic [SEG_W-1:0]              r_seg;
    logic                          r_dp;

    assign w_idx      = r_state;
    assign w_slot_end = (r_presc == PRESC_LAST);
    assign w_digit    = r_digits[w_idx];

    // Shadow register: capture all digits and dp positions together on the load strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digits <= '0;
            r_dp_sel <= '0;
        end else if (i_load) begin
            r_digits <= {i_d3, i_d2, i_d1, i_d0};
            r_dp_sel <= i_dp_sel;
        end
    end

    // Prescaler: counts cycles within the current digit slot.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_slot_end) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Scan state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= DIG0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan next-state: advance to the next digit when the slot ends.
    always_comb begin
        w_state_nxt = r_state;
        if (w_slot_end) begin
            unique case (r_state)
                DIG0: w_state_nxt = DIG1;
                DIG1: w_state_nxt = DIG2;
                DIG2: w_state_nxt = DIG3;
                DIG3: w_state_nxt = DIG0;
            endcase
        end
    end

    bcd_to_sseg u_bcd_to_sseg (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

`ifdef SSEG_LEAD_ZERO_BLANK_EN
    logic w_blank;

    // A digit is blanked when it and every more-significant digit are zero and it carries no
    // point; the rightmost digit always shows.
    always_comb begin
        w_blank = 1'b0;
        if ((r_state != DIG0) && !r_dp_sel[w_idx]) begin
            w_blank = 1'b1;
            for (int j = 0; j < int'(NUM_DIG); j++) begin
                if ((j >= int'(w_idx)) && (r_digits[j] != '0)) begin
                    w_blank = 1'b0;
                end
            end
        end
    end

    assign w_seg_nxt = w_blank ? SEG_OFF : w_seg_dec;
`else
    assign w_seg_nxt = w_seg_dec;
`endif

    // Anode pattern: all off during the blanking window, otherwise only the current digit.
    always_comb begin
        w_an_nxt = '1;
        if (r_presc >= BLANK_END) begin
            w_an_nxt = ~(4'b0001 << w_idx);
        end
    end

    // Output registers; segments and point update only at the start of a slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an <= w_an_nxt;
            if (r_presc == '0) begin
                r_seg <= w_seg_nxt;
                r_dp  <= ~r_dp_sel[w_idx];
            end
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;
    assign o_dp  = r_dp;

endmodule
